// File: rtl/feeder_pkg.sv
// Shared definitions for the instruction-memory feeder: FSM encoding and defaults.
package feeder_pkg;

    localparam int unsigned AW_DEFAULT = 6;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/imem_ram.sv
// Program buffer: 32-bit wide, synchronous write port, asynchronous read port.
module imem_ram #(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_feeder.sv
// Instruction-side responder: loads a program over valid/ready, then serves
// zero-latency fetches to a single-cycle CPU and halts it on a bad PC.
module imem_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned AW       = AW_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic          reload,
    input  logic [31:0]   pc,
    output logic [31:0]   instruction,
    output logic          cpu_run,
    output logic          fault,
    output logic          trunc,
    output logic [AW:0]   prog_len
);

    localparam logic [AW-1:0] LAST_PTR = '1;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] index;
    logic [31:0]   rd_data;
    logic          fetch_ok;
    logic          accept;
    logic          we;

    assign index  = pc[AW+1:2];
    assign accept = (state == ST_LOAD) && load_valid && load_ready;
    // A word arriving together with reload belongs to the discarded program.
    assign we     = accept && !reload;

    imem_ram #(.AW(AW)) u_ram (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_ptr),
        .wr_data (load_data),
        .rd_addr (index),
        .rd_data (rd_data)
    );

    always_comb begin
        fetch_ok = (pc[1:0] == 2'b00) && ({1'b0, index} < prog_len)
                   && (pc[31:AW+2] == '0);
    end

    // Fetch response must be combinational: the CPU consumes it in the same cycle.
    always_comb begin
        instruction = NOP_WORD;
        cpu_run     = 1'b0;
        if ((state == ST_RUN) && fetch_ok) begin
            instruction = rd_data;
            cpu_run     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            state      <= ST_LOAD;
            wr_ptr     <= '0;
            prog_len   <= '0;
            fault      <= 1'b0;
            trunc      <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        wr_ptr   <= wr_ptr + AW'(1);
                        prog_len <= prog_len + (AW+1)'(1);
                        if (load_last) begin
                            state      <= ST_RUN;
                            load_ready <= 1'b0;
                        end else if (wr_ptr == LAST_PTR) begin
                            state      <= ST_RUN;
                            load_ready <= 1'b0;
                            trunc      <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!fetch_ok) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    state      <= ST_LOAD;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_feeder.md
Name: imem_feeder

Overview:
- Instruction-side responder for the single-cycle CPU (`top_for_single`). It supplies `instruction` for the CPU-driven `PC`.
- Holds a small program buffer, filled word by word over a valid/ready load port. The CPU is released only after loading completes.
- Each fetch is checked: a misaligned or out-of-range PC returns NOP and halts the CPU.
- Replaces the constant instruction drive used in simulation benches, so real programs can run.

Parameters:
- AW, 6, word-address width; buffer depth = 2**AW words.
- NOP_WORD, 32'h00000000, word returned whenever no valid instruction exists.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- load_valid  in  1  loader presents a word
- load_data  in  32  instruction word to store
- load_last  in  1  qualifies the final word of a program
- load_ready  out  1  feeder accepts a word this cycle
- reload  in  1  one-cycle pulse: discard the program and re-enter LOAD
- pc  in  32  CPU program counter (byte address)
- instruction  out  32  instruction for `pc`
- cpu_run  out  1  CPU clock enable / not-stalled
- fault  out  1  sticky fetch fault
- trunc  out  1  sticky: program exceeded depth
- prog_len  out  AW+1  number of words loaded

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high.
- States:
  - LOAD: reset state.
  - RUN: program executing.
  - FAULT: halted after a bad fetch.
- Reset values (rst=1 at a clock edge, from any state, including mid-load):
  - state=LOAD, wr_ptr=0, prog_len=0, fault=0, trunc=0, cpu_run=0.
  - load_ready=1 from the following cycle.
  - Buffer contents are not cleared.
- LOAD:
  - load_ready=1, cpu_run=0, instruction=NOP_WORD.
  - On load_valid & load_ready: mem[wr_ptr] <= load_data, wr_ptr++, prog_len++.
  - If load_last is also set: go to RUN next cycle.
  - If the accepted word fills the last slot (wr_ptr==2**AW-1) without load_last: set trunc=1 and go to RUN.
  - load_valid=0 stalls indefinitely with no state change.
  - load_last with load_valid=0 is ignored.
- RUN:
  - load_ready=0, cpu_run=1.
  - Word index = pc[AW+1:2].
  - Fetch is valid iff pc[1:0]==0, index < prog_len, and pc[31:AW+2]==0.
  - Valid fetch: instruction = mem[index], combinational from pc, same cycle (the single-cycle CPU requires zero latency).
  - Invalid fetch:
    - Same cycle: instruction=NOP_WORD, cpu_run=0.
    - Next edge: fault=1, state=FAULT.
- FAULT:
  - cpu_run=0, instruction=NOP_WORD, load_ready=0.
  - Exited only by reload or rst.
- reload (RUN or FAULT):
  - Next cycle: state=LOAD, wr_ptr=0, prog_len=0, fault=0, trunc=0.
  - reload in LOAD also restarts: wr_ptr=0, prog_len=0. A word accepted in the same cycle is dropped.
- Precedence: rst > reload > load transfer > fetch check.
- prog_len == 0 is impossible in RUN, because at least one word is always accepted before leaving LOAD.
- prog_len saturates at 2**AW; it is AW+1 bits wide so the full value fits.
- Memory: 2**AW x 32, synchronous write, asynchronous read (distributed RAM).
- The wr_ptr counter does not wrap within one load: the full slot forces exit to RUN.

Decomposition:
- Shared package `feeder_pkg`:
  - state encoding (ST_LOAD=2'd0, ST_RUN=2'd1, ST_FAULT=2'd2);
  - NOP constant 32'h00000000;
  - default AW.
- One sub-module: `imem_ram`, a 32-bit wide RAM with a sync write port and an async read port. The FSM, pointer and fetch checker stay in `imem_feeder`.

Test Plan:
- Reset then single-word load: load 32'h02328020 with load_last, then pc=0 → load_ready drops, cpu_run=1, instruction=32'h02328020 in the same cycle, prog_len=1.
- Multi-word load with gaps: load 0x20100005, 0x20110003, 0x02119020 (last) with one-cycle valid gaps → pc=0/4/8 returns each word, prog_len=3, trunc=0.
- Fetch faults:
  - after the 3-word load, pc=12 → instruction=0 and cpu_run=0 the same cycle, fault=1 next cycle;
  - a separate run with pc=6 → same response.
- Overflow, AW=2: load 5 words without last → after 4th word state=RUN, trunc=1, prog_len=4. The 5th word is refused (load_ready=0). pc=12 returns the 4th word.
- Reload from FAULT: pulse reload → load_ready=1, fault=0, prog_len=0, cpu_run=0. A new 1-word program runs correctly.
- Reset mid-load: after 2 of 3 words, assert rst for 1 cycle → prog_len=0, state=LOAD. Reloading 3 words gives prog_len=3, and pc=8 returns the new third word.
